// File: rtl/sub32_pkg.sv
// Shared types and constants for the serial 32-bit subtractor.
// The operand is viewed as an array of SLICE-bit slices so the datapath can index it by the slice counter.
package sub32_pkg;

    localparam int WIDTH    = 32;
    localparam int SLICE    = 4;
    localparam int N_SLICES = WIDTH / SLICE;
    localparam int CNT_W    = $clog2(N_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [N_SLICES-1:0][SLICE-1:0] slice_vec_t;

    // Two's-complement overflow of a - b: operand signs differ and the result sign left a's sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/sub32_serial_if.sv
// Start/done request interface of the serial subtractor: operands in, difference and flags out.
interface sub32_serial_if;
    import sub32_pkg::*;

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ovf;
    logic             z;

    modport master (
        output start, a, b,
        input  busy, done, d, bo, ovf, z
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bo, ovf, z
    );

endinterface

// File: rtl/sub32_serial_cla4.sv
// 4-bit carry-lookahead adder cell: all internal carries are formed directly from generate/propagate terms.
module cla4 (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        co   = c[4];
    end

endmodule

// File: rtl/sub32_serial.sv
// Serial 32-bit subtractor: d = a + ~b + 1, one 4-bit slice per clock through a single cla4 cell.
// Results and flags hold until the next accepted start; an accepted start clears only d.
module sub32_serial
    import sub32_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    sub32_serial_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    slice_vec_t       a_q,     a_d;
    slice_vec_t       b_q,     b_d;
    slice_vec_t       diff_q,  diff_d;
    logic             bo_q,    bo_d;
    logic             ovf_q,   ovf_d;
    logic             z_q,     z_d;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b_n;
    logic [SLICE-1:0] slice_sum;
    logic             slice_co;
    logic             last_slice;

    // The subtrahend is inverted here so cla4 stays a plain adder; the +1 enters as the initial carry.
    always_comb begin
        slice_a    = a_q[cnt_q];
        slice_b_n  = ~b_q[cnt_q];
        last_slice = (cnt_q == CNT_W'(N_SLICES - 1));
    end

    cla4 u_cla4 (
        .s  (slice_sum),
        .co (slice_co),
        .a  (slice_a),
        .b  (slice_b_n),
        .ci (carry_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        ovf_d   = ovf_q;
        z_d     = z_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q] = slice_sum;
                carry_d       = slice_co;
                cnt_d         = cnt_q + CNT_W'(1);
                // Flags are taken from the final slice so they are valid together with done.
                if (last_slice) begin
                    state_d = DONE;
                    bo_d    = ~slice_co;
                    ovf_d   = signed_ovf(a_q[N_SLICES-1][SLICE-1], b_q[N_SLICES-1][SLICE-1],
                                         slice_sum[SLICE-1]);
                    z_d     = (diff_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
            ovf_q   <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
            ovf_q   <= ovf_d;
            z_q     <= z_d;
        end
    end

    // done is masked by reset so an aborted operation never shows a completion pulse.
    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE) && !reset;
        bus.d    = diff_q;
        bus.bo   = bo_q;
        bus.ovf  = ovf_q;
        bus.z    = z_q;
    end

endmodule
